// File: rtl/sum_of_n_pipelined.sv
// Pipelined multi-operand adder: sums NUM_WORDS words per beat through a registered tree and accumulates per packet.
// Optional build macro SUM_OF_N_SATURATE_EN clamps the packet total at 2**ACC_WIDTH-1 instead of wrapping.
//
// state | meaning
// IDLE  | no packet in progress; next beat reaching SA starts a new packet
// ACCUM | packet in progress; acc/ovf hold the partial total
module sum_of_n_pipelined #(
   parameter int WIDTH     = 3,
   parameter int NUM_WORDS = 8,
   parameter int ACC_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_WORDS*WIDTH-1:0] din,
   input  logic                       din_valid,
   input  logic                       din_last,
   output logic                       din_ready,
   output logic [ACC_WIDTH-1:0]       sum,
   output logic                       sum_valid,
   input  logic                       sum_ready,
   output logic                       sum_ovf
);

   localparam int L  = $clog2(NUM_WORDS);
   localparam int P  = 1 << L;
   localparam int TW = WIDTH + L;
   localparam int EW = ((TW > ACC_WIDTH) ? TW : ACC_WIDTH) + 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   // Level 0 is the S0 input register; level k holds the S(k) partial sums.
   logic [TW-1:0]        tree [0:L][0:P-1];
   logic [L:0]           stg_v;
   logic [L:0]           stg_last;
   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic                 ovf;
   logic                 adv;
   logic [EW-1:0]        total;
   logic                 ovf_next;
   logic [ACC_WIDTH-1:0] acc_next;

   assign adv       = !sum_valid || sum_ready;
   assign din_ready = adv && rst_n;

   always_comb begin
      total    = EW'(tree[L][0]) + ((state == ACCUM) ? EW'(acc) : '0);
      ovf_next = ((state == ACCUM) && ovf) || (total[EW-1:ACC_WIDTH] != '0);
`ifdef SUM_OF_N_SATURATE_EN
      acc_next = ovf_next ? '1 : total[ACC_WIDTH-1:0];
`else
      acc_next = total[ACC_WIDTH-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_v     <= '0;
         stg_last  <= '0;
         state     <= IDLE;
         acc       <= '0;
         ovf       <= 1'b0;
         sum       <= '0;
         sum_valid <= 1'b0;
         sum_ovf   <= 1'b0;
      end else if (adv) begin
         stg_v[0]    <= din_valid;
         stg_last[0] <= din_valid && din_last;
         for (int k = 1; k <= L; k++) begin
            stg_v[k]    <= stg_v[k-1];
            stg_last[k] <= stg_last[k-1];
         end

         // Missing leaves of a non-power-of-2 tree are tied to zero.
         for (int j = 0; j < P; j++) begin
            if (j < NUM_WORDS)
               tree[0][j] <= TW'(din[j*WIDTH +: WIDTH]);
            else
               tree[0][j] <= '0;
         end
         for (int k = 0; k < L; k++) begin
            for (int j = 0; j < P; j++) begin
               if (j < (P >> (k + 1)))
                  tree[k+1][j] <= tree[k][2*j] + tree[k][2*j+1];
               else
                  tree[k+1][j] <= '0;
            end
         end

         sum_valid <= 1'b0;
         if (stg_v[L]) begin
            if (stg_last[L]) begin
               sum       <= acc_next;
               sum_ovf   <= ovf_next;
               sum_valid <= 1'b1;
               state     <= IDLE;
               acc       <= '0;
               ovf       <= 1'b0;
            end else begin
               acc   <= acc_next;
               ovf   <= ovf_next;
               state <= ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_sum_of_n_pipelined.sv
// Directed bench for sum_of_n_pipelined: a 2-word/3-bit/4-bit-acc instance and a default instance.
// Results are collected by handshake monitors and checked against hand-computed totals and latencies.
module tb_sum_of_n_pipelined;

`ifdef SUM_OF_N_SATURATE_EN
   localparam int EXP_OVF_SUM = 255;
`else
   localparam int EXP_OVF_SUM = 24;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [5:0]  a_din;
   logic        a_din_valid, a_din_last, a_din_ready;
   logic [3:0]  a_sum;
   logic        a_sum_valid, a_sum_ready, a_sum_ovf;

   logic [23:0] b_din;
   logic        b_din_valid, b_din_last, b_din_ready;
   logic [7:0]  b_sum;
   logic        b_sum_valid, b_sum_ready, b_sum_ovf;

   sum_of_n_pipelined #(.WIDTH(3), .NUM_WORDS(2), .ACC_WIDTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_din_valid), .din_last(a_din_last),
      .din_ready(a_din_ready), .sum(a_sum), .sum_valid(a_sum_valid), .sum_ready(a_sum_ready),
      .sum_ovf(a_sum_ovf));

   sum_of_n_pipelined dut_b (
      .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid), .din_last(b_din_last),
      .din_ready(b_din_ready), .sum(b_sum), .sum_valid(b_sum_valid), .sum_ready(b_sum_ready),
      .sum_ovf(b_sum_ovf));

   int a_q_sum[$], a_q_ovf[$], a_q_cyc[$];
   int b_q_sum[$], b_q_ovf[$], b_q_cyc[$];

   always @(negedge clk) begin
      if (rst_n === 1'b1 && a_sum_valid === 1'b1 && a_sum_ready === 1'b1) begin
         a_q_sum.push_back(int'(a_sum)); a_q_ovf.push_back(int'(a_sum_ovf)); a_q_cyc.push_back(cyc);
      end
      if (rst_n === 1'b1 && b_sum_valid === 1'b1 && b_sum_ready === 1'b1) begin
         b_q_sum.push_back(int'(b_sum)); b_q_ovf.push_back(int'(b_sum_ovf)); b_q_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic a_beat(input logic [5:0] d, input logic last, output int t);
      logic rd;
      int   n = 0;
      a_din = d; a_din_valid = 1'b1; a_din_last = last;
      do begin
         @(negedge clk); rd = a_din_ready; t = cyc;
         @(posedge clk); #1; n++;
      end while (!rd && n < 50);
      if (!rd) begin
         checks++; errors++;
         $display("FAIL a_beat_timeout: din_ready=%b after %0d cycles, required 1", rd, n);
      end
   endtask

   task automatic b_beat(input logic [23:0] d, input logic last, output int t);
      logic rd;
      int   n = 0;
      b_din = d; b_din_valid = 1'b1; b_din_last = last;
      do begin
         @(negedge clk); rd = b_din_ready; t = cyc;
         @(posedge clk); #1; n++;
      end while (!rd && n < 50);
      if (!rd) begin
         checks++; errors++;
         $display("FAIL b_beat_timeout: din_ready=%b after %0d cycles, required 1", rd, n);
      end
   endtask

   task automatic idle_all();
      a_din_valid = 1'b0; a_din_last = 1'b0;
      b_din_valid = 1'b0; b_din_last = 1'b0;
   endtask

   task automatic clear_q();
      a_q_sum.delete(); a_q_ovf.delete(); a_q_cyc.delete();
      b_q_sum.delete(); b_q_ovf.delete(); b_q_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_din = '0; b_din = '0;
      idle_all();
      a_sum_ready = 1'b1; b_sum_ready = 1'b1;
      repeat (3) tick();
      checks += 6;
      if (b_sum_valid !== 1'b0) begin errors++; $display("FAIL rst_b_sum_valid: got %b required 0", b_sum_valid); end
      if (b_sum !== 8'd0)       begin errors++; $display("FAIL rst_b_sum: got %0d required 0", b_sum); end
      if (b_sum_ovf !== 1'b0)   begin errors++; $display("FAIL rst_b_sum_ovf: got %b required 0", b_sum_ovf); end
      if (b_din_ready !== 1'b0) begin errors++; $display("FAIL rst_b_din_ready: got %b required 0", b_din_ready); end
      if (a_sum_valid !== 1'b0) begin errors++; $display("FAIL rst_a_sum_valid: got %b required 0", a_sum_valid); end
      if (a_din_ready !== 1'b0) begin errors++; $display("FAIL rst_a_din_ready: got %b required 0", a_din_ready); end
      rst_n = 1'b1;
      #1;
      checks++;
      if (b_din_ready !== 1'b1) begin errors++; $display("FAIL rst_release_din_ready: got %b required 1", b_din_ready); end
      tick();
   endtask

   task automatic test_pairs();
      int t_arr[64];
      clear_q();
      for (int i = 0; i < 64; i++) a_beat(6'(i), 1'b1, t_arr[i]);
      idle_all();
      repeat (8) tick();
      checks++;
      if (a_q_sum.size() != 64) begin errors++; $display("FAIL pairs_count: got %0d results required 64", a_q_sum.size()); end
      else begin
         for (int i = 0; i < 64; i++) begin
            checks += 4;
            if (a_q_sum[i] != (i % 8) + (i / 8))
               begin errors++; $display("FAIL pairs_sum[%0d]: got %0d required %0d", i, a_q_sum[i], (i % 8) + (i / 8)); end
            if (a_q_ovf[i] != 0)
               begin errors++; $display("FAIL pairs_ovf[%0d]: got %0d required 0", i, a_q_ovf[i]); end
            if (a_q_cyc[i] != t_arr[i] + 3)
               begin errors++; $display("FAIL pairs_latency[%0d]: got cycle %0d required %0d", i, a_q_cyc[i], t_arr[i] + 3); end
            if (a_q_cyc[i] != a_q_cyc[0] + i)
               begin errors++; $display("FAIL pairs_rate[%0d]: got cycle %0d required %0d", i, a_q_cyc[i], a_q_cyc[0] + i); end
         end
      end
   endtask

   task automatic test_latency();
      int t;
      clear_q();
      b_beat({8{3'd7}}, 1'b1, t);
      idle_all();
      repeat (10) tick();
      checks++;
      if (b_q_sum.size() != 1) begin errors++; $display("FAIL lat_count: got %0d results required 1", b_q_sum.size()); end
      else begin
         checks += 3;
         if (b_q_sum[0] != 56) begin errors++; $display("FAIL lat_sum: got %0d required 56", b_q_sum[0]); end
         if (b_q_ovf[0] != 0)  begin errors++; $display("FAIL lat_ovf: got %0d required 0", b_q_ovf[0]); end
         if (b_q_cyc[0] != t + 5) begin errors++; $display("FAIL lat_cycle: got %0d required %0d", b_q_cyc[0], t + 5); end
      end
   endtask

   task automatic test_back_to_back();
      int t0, t1, t2;
      clear_q();
      b_beat({8{3'd7}}, 1'b0, t0);
      b_beat({8{3'd7}}, 1'b1, t1);
      b_beat({8{3'd1}}, 1'b1, t2);
      idle_all();
      repeat (10) tick();
      checks++;
      if (b_q_sum.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d results required 2", b_q_sum.size()); end
      else begin
         checks += 5;
         if (b_q_sum[0] != 112) begin errors++; $display("FAIL b2b_sum0: got %0d required 112", b_q_sum[0]); end
         if (b_q_sum[1] != 8)   begin errors++; $display("FAIL b2b_sum1: got %0d required 8", b_q_sum[1]); end
         if (b_q_ovf[0] != 0 || b_q_ovf[1] != 0)
            begin errors++; $display("FAIL b2b_ovf: got %0d,%0d required 0,0", b_q_ovf[0], b_q_ovf[1]); end
         if (b_q_cyc[0] != t1 + 5) begin errors++; $display("FAIL b2b_cycle0: got %0d required %0d", b_q_cyc[0], t1 + 5); end
         if (b_q_cyc[1] != b_q_cyc[0] + 1)
            begin errors++; $display("FAIL b2b_gap: got %0d required %0d", b_q_cyc[1], b_q_cyc[0] + 1); end
      end
   endtask

   task automatic test_overflow();
      int t;
      clear_q();
      for (int i = 0; i < 5; i++) b_beat({8{3'd7}}, (i == 4), t);
      b_beat({8{3'd1}}, 1'b1, t);
      idle_all();
      repeat (10) tick();
      checks++;
      if (b_q_sum.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d results required 2", b_q_sum.size()); end
      else begin
         checks += 4;
         if (b_q_sum[0] != EXP_OVF_SUM) begin errors++; $display("FAIL ovf_sum: got %0d required %0d", b_q_sum[0], EXP_OVF_SUM); end
         if (b_q_ovf[0] != 1) begin errors++; $display("FAIL ovf_flag: got %0d required 1", b_q_ovf[0]); end
         if (b_q_sum[1] != 8) begin errors++; $display("FAIL ovf_next_sum: got %0d required 8", b_q_sum[1]); end
         if (b_q_ovf[1] != 0) begin errors++; $display("FAIL ovf_next_flag: got %0d required 0", b_q_ovf[1]); end
      end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int stall = 0;
      clear_q();
      b_sum_ready = 1'b1;
      for (int c = 0; c < 40 && !(idx == 6 && b_q_sum.size() == 6); c++) begin
         if (idx < 6) begin
            b_din = {8{3'(idx + 1)}}; b_din_valid = 1'b1; b_din_last = 1'b1;
         end else begin
            b_din_valid = 1'b0; b_din_last = 1'b0;
         end
         if (b_sum_valid === 1'b1 && b_q_sum.size() == 1 && stall < 3) begin
            b_sum_ready = 1'b0; stall++;
         end else begin
            b_sum_ready = 1'b1;
         end
         @(negedge clk);
         if (b_sum_ready == 1'b0) begin
            checks += 2;
            if (b_din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready: got %b required 0", b_din_ready); end
            if (b_sum !== 8'd16) begin errors++; $display("FAIL bp_sum_hold: got %0d required 16", b_sum); end
         end
         if (b_din_ready === 1'b1 && b_din_valid === 1'b1) idx++;
         @(posedge clk); #1;
      end
      b_sum_ready = 1'b1;
      idle_all();
      checks += 2;
      if (stall != 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d required 3", stall); end
      if (b_q_sum.size() != 6) begin errors++; $display("FAIL bp_count: got %0d results required 6", b_q_sum.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks += 2;
            if (b_q_sum[i] != 8 * (i + 1))
               begin errors++; $display("FAIL bp_sum[%0d]: got %0d required %0d", i, b_q_sum[i], 8 * (i + 1)); end
            if (b_q_ovf[i] != 0)
               begin errors++; $display("FAIL bp_ovf[%0d]: got %0d required 0", i, b_q_ovf[i]); end
         end
      end
      repeat (4) tick();
   endtask

   task automatic test_reset_midpacket();
      int t;
      clear_q();
      b_beat({8{3'd7}}, 1'b0, t);
      b_beat({8{3'd7}}, 1'b0, t);
      idle_all();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      b_beat({8{3'd2}}, 1'b1, t);
      idle_all();
      repeat (10) tick();
      checks++;
      if (b_q_sum.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d results required 1", b_q_sum.size()); end
      else begin
         checks += 2;
         if (b_q_sum[0] != 16) begin errors++; $display("FAIL midrst_sum: got %0d required 16", b_q_sum[0]); end
         if (b_q_ovf[0] != 0)  begin errors++; $display("FAIL midrst_ovf: got %0d required 0", b_q_ovf[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_pairs();
      test_latency();
      test_back_to_back();
      test_overflow();
      test_backpressure();
      test_reset_midpacket();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
